// File: rtl/heartrate_window_if.sv
// -----------------------------------------------------------------------------
// heartrate_window_if
//   Bundles the sample/beat inputs and the rate outputs of heartrate_window.
//   master : beat-detector side (drives sample_en / hb_detect, reads rate).
//   slave  : heartrate_window side.
// Signals:
//   sample_en  - one-cycle sample strobe
//   hb_detect  - beat indication, meaningful only while sample_en = 1
//   rate       - beats inside the current window (CNT_W bits)
//   rate_valid - window has been filled since reset
//   rate_upd   - one-cycle pulse after each rate update
// -----------------------------------------------------------------------------
interface heartrate_window_if #(
    parameter int CNT_W = 11
);
    logic             sample_en;
    logic             hb_detect;
    logic [CNT_W-1:0] rate;
    logic             rate_valid;
    logic             rate_upd;

    modport master (
        output sample_en,
        output hb_detect,
        input  rate,
        input  rate_valid,
        input  rate_upd
    );

    modport slave (
        input  sample_en,
        input  hb_detect,
        output rate,
        output rate_valid,
        output rate_upd
    );
endinterface

// File: rtl/heartrate_window.sv
// -----------------------------------------------------------------------------
// heartrate_window
//   Sliding-window heartbeat counter. Keeps a WINDOW-deep 1-bit delay line of
//   sampled beats and a running count of the ones inside it: every sample
//   strobe adds the new beat and removes the one leaving the window.
//
// Ports:
//   clock  - system clock
//   reset  - synchronous, active-high reset
//   hb_if  - heartrate_window_if.slave (sample_en, hb_detect in;
//            rate, rate_valid, rate_upd out)
//
// Optional feature (compile-time macro HB_REFRACTORY_EN):
//   After an accepted beat, the next REFRACT strobes force beat = 0, so a long
//   detector pulse is counted once. Without the macro no counter is built and
//   REFRACT is unused.
// -----------------------------------------------------------------------------
module heartrate_window #(
    parameter int WINDOW  = 1024,
    parameter int CNT_W   = 11,
    parameter int PTR_W   = 10,
    parameter int REFRACT = 50
) (
    input  logic                   clock,
    input  logic                   reset,
    heartrate_window_if.slave      hb_if
);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WINDOW - 1);

    // Delay line is data only: it is never reset; filled_q masks stale entries.
    logic             line_q [0:WINDOW-1];

    logic [PTR_W-1:0] ptr_q,    ptr_d;
    logic             filled_q, filled_d;
    logic [CNT_W-1:0] rate_q,   rate_d;
    logic             upd_q,    upd_d;
    logic             beat;
    logic             old_bit;

`ifdef HB_REFRACTORY_EN
    logic [15:0]      refr_q,   refr_d;
`endif

    always_comb begin
        beat     = hb_if.hb_detect;
        ptr_d    = ptr_q;
        filled_d = filled_q;
        rate_d   = rate_q;
        upd_d    = 1'b0;

`ifdef HB_REFRACTORY_EN
        refr_d = refr_q;
        if (hb_if.sample_en) begin
            if (refr_q != 16'd0) begin
                // Still in the refractory interval: swallow the detector.
                beat   = 1'b0;
                refr_d = refr_q - 16'd1;
            end else if (hb_if.hb_detect) begin
                refr_d = 16'(REFRACT);
            end
        end
`endif

        // Until the first wrap the slot under ptr holds nothing from this run.
        old_bit = filled_q ? line_q[ptr_q] : 1'b0;

        if (hb_if.sample_en) begin
            upd_d  = 1'b1;
            // old_bit = 1 only for a sample previously added, so no underflow;
            // rate never exceeds WINDOW, so no overflow either.
            rate_d = rate_q + CNT_W'(beat) - CNT_W'(old_bit);
            if (ptr_q == LAST_PTR) begin
                ptr_d    = '0;
                filled_d = 1'b1;
            end else begin
                ptr_d = ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q    <= '0;
            filled_q <= 1'b0;
            rate_q   <= '0;
            upd_q    <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            filled_q <= filled_d;
            rate_q   <= rate_d;
            upd_q    <= upd_d;
        end
    end

`ifdef HB_REFRACTORY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            refr_q <= 16'd0;
        end else begin
            refr_q <= refr_d;
        end
    end
`endif

    // Writes are suppressed during reset so that the pointer and line agree.
    always_ff @(posedge clock) begin
        if (!reset && hb_if.sample_en) begin
            line_q[ptr_q] <= beat;
        end
    end

    assign hb_if.rate       = rate_q;
    assign hb_if.rate_valid = filled_q;
    assign hb_if.rate_upd   = upd_q;

endmodule
